// File: rtl/program_loader_if.sv
// Byte-stream receive handshake plus memory write port between the loader and its environment.
// Latency: none, wires only.
// Backpressure: rx_rdy from the loader throttles rx_vld/rx_dat from the sender.
interface program_loader_if #(
   parameter int AddrWidth = 8,
   parameter int DataWidth = 16
);
   logic [7:0]           rx_dat;
   logic                 rx_vld;
   logic                 rx_rdy;
   logic [AddrWidth-1:0] mem_addr;
   logic [DataWidth-1:0] mem_din;
   logic                 mem_wr;
   logic                 mem_en;

   // Loader side: consumes bytes, masters the memory write port.
   modport master (
      input  rx_dat, rx_vld,
      output rx_rdy, mem_addr, mem_din, mem_wr, mem_en
   );

   // Environment side: byte sender and memory.
   modport slave (
      output rx_dat, rx_vld,
      input  rx_rdy, mem_addr, mem_din, mem_wr, mem_en
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: packs a byte stream (first byte = [15:8]) into words written from address 0, then releases the CPU hold.
// Latency: byte accepted in LO at edge N -> MEM write in cycle N+1; after the last word Done/CPU release from cycle N+2.
// Backpressure: rx_rdy is high only in HI/LO (and CHK); it drops for the write cycle, so the sender holds its byte.
// Optional: define CHECKSUM_EN to append one 8-bit sum byte, checked before the CPU is released.
module program_loader #(
   parameter int AddrWidth = 8,
   parameter int DataWidth = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 start_i,
   input  logic [AddrWidth:0]   len_i,
   program_loader_if.master     bus,
   output logic                 cpu_hold_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WR,
      S_DONE
`ifdef CHECKSUM_EN
      ,
      S_CHK,
      S_FAIL
`endif
   } state_t;

   // Largest image is the whole address space; cnt/len are one bit wider so that count is representable.
   localparam logic [AddrWidth:0] MaxLen = {1'b1, {AddrWidth{1'b0}}};
   localparam logic [AddrWidth:0] One    = {{AddrWidth{1'b0}}, 1'b1};

   state_t                 state_q;
   logic [AddrWidth:0]     cnt_q;
   logic [AddrWidth:0]     len_q;
   logic [7:0]             hi_q;
   logic                   rx_rdy_q;
   logic                   mem_wr_q;
   logic [AddrWidth-1:0]   mem_addr_q;
   logic [DataWidth-1:0]   mem_din_q;
   logic                   cpu_hold_q;
   logic                   busy_q;
   logic                   done_q;
`ifdef CHECKSUM_EN
   logic [7:0]             sum_q;
   logic                   err_q;
`endif

   logic [AddrWidth:0]     len_d;
   logic [AddrWidth:0]     cnt_inc_d;
   logic                   xfer;

   // Oversized requests are clamped so the address never wraps.
   assign len_d     = (len_i > MaxLen) ? MaxLen : len_i;
   assign cnt_inc_d = cnt_q + One;
   assign xfer      = bus.rx_vld & rx_rdy_q;

   // Load sequencer: state, counters and every output are registered here.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         hi_q       <= '0;
         rx_rdy_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         cpu_hold_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef CHECKSUM_EN
         sum_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         // Write strobe lasts exactly one cycle; only the LO transfer raises it.
         mem_wr_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE
`ifdef CHECKSUM_EN
            , S_FAIL
`endif
            : begin
               if (start_i) begin
                  len_q      <= len_d;
                  cnt_q      <= '0;
                  cpu_hold_q <= 1'b1;
                  done_q     <= 1'b0;
`ifdef CHECKSUM_EN
                  sum_q      <= '0;
                  err_q      <= 1'b0;
`endif
                  if (len_d == '0) begin
`ifdef CHECKSUM_EN
                     state_q    <= S_CHK;
                     rx_rdy_q   <= 1'b1;
                     busy_q     <= 1'b1;
`else
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                     busy_q     <= 1'b0;
`endif
                  end else begin
                     state_q  <= S_HI;
                     rx_rdy_q <= 1'b1;
                     busy_q   <= 1'b1;
                  end
               end
            end
            S_HI: begin
               if (xfer) begin
                  hi_q    <= bus.rx_dat;
`ifdef CHECKSUM_EN
                  sum_q   <= sum_q + bus.rx_dat;
`endif
                  state_q <= S_LO;
               end
            end
            S_LO: begin
               if (xfer) begin
                  mem_din_q  <= {hi_q, bus.rx_dat};
                  mem_addr_q <= cnt_q[AddrWidth-1:0];
                  mem_wr_q   <= 1'b1;
                  rx_rdy_q   <= 1'b0;
`ifdef CHECKSUM_EN
                  sum_q      <= sum_q + bus.rx_dat;
`endif
                  state_q    <= S_WR;
               end
            end
            S_WR: begin
               cnt_q <= cnt_inc_d;
               if (cnt_inc_d == len_q) begin
`ifdef CHECKSUM_EN
                  state_q    <= S_CHK;
                  rx_rdy_q   <= 1'b1;
`else
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  cpu_hold_q <= 1'b0;
                  busy_q     <= 1'b0;
`endif
               end else begin
                  state_q  <= S_HI;
                  rx_rdy_q <= 1'b1;
               end
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
               if (xfer) begin
                  rx_rdy_q <= 1'b0;
                  busy_q   <= 1'b0;
                  if (bus.rx_dat == sum_q) begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                  end else begin
                     // Bad image: keep the CPU held until the host restarts the load.
                     state_q <= S_FAIL;
                     err_q   <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_q  <= S_IDLE;
               rx_rdy_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_rdy   = rx_rdy_q;
   assign bus.mem_wr   = mem_wr_q;
   assign bus.mem_en   = mem_wr_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign cpu_hold_o   = cpu_hold_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
`ifdef CHECKSUM_EN
   assign err_o        = err_q;
`else
   assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed boundary sequences, a table of loads, and randomized loads with stalls.
// Expected memory contents come from a byte-pair model (word i = {b[2i], b[2i+1]} at address i).
// Works with or without CHECKSUM_EN defined.
`timescale 1ns/1ps
module tb_program_loader;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW:0]   len;
   logic          cpu_hold, busy, done, err;

   int            checks = 0;
   int            errors = 0;
   int            en_bad = 0;
   logic [23:0]   wr_log[$];

   program_loader_if #(.AddrWidth(AW), .DataWidth(16)) bus();

   program_loader #(.AddrWidth(AW), .DataWidth(16)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start),
      .len_i      (len),
      .bus        (bus),
      .cpu_hold_o (cpu_hold),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   // Memory-side monitor: record every write {addr, data}, and track mem_en vs mem_wr.
   always @(negedge clk) begin
      if (bus.mem_wr) wr_log.push_back({bus.mem_addr, bus.mem_din});
      if (bus.mem_en !== bus.mem_wr) en_bad++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model_sum(input logic [7:0] q[$]);
      logic [7:0] s;
      s = 8'h00;
      foreach (q[i]) s = s + q[i];
      return s;
   endfunction

   task automatic start_load(input logic [AW:0] ln);
      @(negedge clk);
      start = 1'b1;
      len   = ln;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drives bytes in order; a byte counts as taken when rx_vld and rx_rdy are both high before the edge.
   task automatic send_bytes(input logic [7:0] q[$], input bit stall, input string name);
      int idx;
      int cyc;
      idx = 0;
      cyc = 0;
      while (idx < q.size() && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (stall && ($urandom_range(0, 2) == 0)) begin
            bus.rx_vld = 1'b0;
         end else begin
            bus.rx_vld = 1'b1;
            bus.rx_dat = q[idx];
            if (bus.rx_rdy) idx++;
         end
      end
      if (idx < q.size()) check({name, "_send_timeout"}, idx, q.size());
   endtask

   task automatic wait_end(input string name);
      for (int c = 0; c < 100; c++) begin
         if (done || err) break;
         @(negedge clk);
      end
      check({name, "_end_seen"}, done | err, 1'b1);
   endtask

   // Sends image bytes (plus the correct checksum when enabled), ends the stream, waits for completion.
   task automatic send_and_finish(input logic [7:0] q[$], input bit stall, input string name);
      logic [7:0] d[$];
      d = q;
`ifdef CHECKSUM_EN
      d.push_back(model_sum(q));
`endif
      send_bytes(d, stall, name);
      @(negedge clk);
      bus.rx_vld = 1'b0;
      wait_end(name);
   endtask

   task automatic check_log(input string name, input logic [7:0] b[$]);
      int n;
      n = b.size() / 2;
      check({name, "_nwr"}, wr_log.size(), n);
      for (int i = 0; i < n && i < wr_log.size(); i++)
         check($sformatf("%s_w%0d", name, i), wr_log[i], {8'(i), b[2*i], b[2*i+1]});
   endtask

   task automatic run_load(input string name, input logic [AW:0] ln, input int nwords, input bit stall);
      logic [7:0] q[$];
      for (int i = 0; i < 2 * nwords; i++) q.push_back(8'($urandom));
      wr_log.delete();
      start_load(ln);
      send_and_finish(q, stall, name);
      check_log(name, q);
      check({name, "_err"}, err, 1'b0);
      check({name, "_busy"}, busy, 1'b0);
   endtask

   typedef struct {
      logic [AW:0] len;
      int          nwords;
      bit          stall;
      logic        exp_done;
      logic        exp_hold;
   } vec_t;

   initial begin
      vec_t       vecs[$];
      logic [7:0] q[$];
      logic [7:0] q3[$];
      logic [7:0] s1[$];
      logic [AW:0] rl;

      vecs.push_back('{len: 9'd1,   nwords: 1,   stall: 1'b0, exp_done: 1'b1, exp_hold: 1'b0});
      vecs.push_back('{len: 9'd3,   nwords: 3,   stall: 1'b1, exp_done: 1'b1, exp_hold: 1'b0});
      vecs.push_back('{len: 9'd4,   nwords: 4,   stall: 1'b1, exp_done: 1'b1, exp_hold: 1'b0});
      vecs.push_back('{len: 9'd256, nwords: 256, stall: 1'b0, exp_done: 1'b1, exp_hold: 1'b0});
      vecs.push_back('{len: 9'd300, nwords: 256, stall: 1'b0, exp_done: 1'b1, exp_hold: 1'b0});

      rst_n      = 1'b0;
      start      = 1'b0;
      len        = '0;
      bus.rx_vld = 1'b0;
      bus.rx_dat = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_rdy",  bus.rx_rdy,   1'b0);
      check("rst_wr",   bus.mem_wr,   1'b0);
      check("rst_en",   bus.mem_en,   1'b0);
      check("rst_addr", bus.mem_addr, 8'h00);
      check("rst_din",  bus.mem_din,  16'h0000);
      check("rst_hold", cpu_hold,     1'b1);
      check("rst_busy", busy,         1'b0);
      check("rst_done", done,         1'b0);
      check("rst_err",  err,          1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-load after three bytes
      wr_log.delete();
      start_load(9'd2);
      q3 = {8'h12, 8'h34, 8'hAB};
      send_bytes(q3, 1'b0, "midrst");
      @(negedge clk);
      bus.rx_vld = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_hold", cpu_hold,   1'b1);
      check("midrst_busy", busy,       1'b0);
      check("midrst_done", done,       1'b0);
      check("midrst_wr",   bus.mem_wr, 1'b0);
      check("midrst_rdy",  bus.rx_rdy, 1'b0);
      check("midrst_partial_nwr", wr_log.size(), 1);
      rst_n = 1'b1;

      // Len = 0 from IDLE
      wr_log.delete();
      start_load(9'd0);
`ifdef CHECKSUM_EN
      check("len0_chk_rdy", bus.rx_rdy, 1'b1);
      s1 = {8'h00};
      send_bytes(s1, 1'b0, "len0");
      @(negedge clk);
      bus.rx_vld = 1'b0;
      wait_end("len0");
`else
      check("len0_done_next", done, 1'b1);
      check("len0_hold", cpu_hold, 1'b0);
`endif
      repeat (3) @(negedge clk);
      check("len0_nwr", wr_log.size(), 0);
      check("len0_done", done, 1'b1);

      // Basic load with cycle-exact timing of the last word
      wr_log.delete();
      start_load(9'd2);
      q = {8'h12, 8'h34, 8'hAB, 8'hCD};
      send_bytes(q, 1'b0, "basic");
      @(negedge clk);
      bus.rx_vld = 1'b0;
      check("basic_wr_n1",   bus.mem_wr, 1'b1);
      check("basic_done_n1", done,       1'b0);
      check("basic_hold_n1", cpu_hold,   1'b1);
      @(negedge clk);
      check("basic_wr_n2", bus.mem_wr, 1'b0);
`ifdef CHECKSUM_EN
      check("basic_chk_rdy", bus.rx_rdy, 1'b1);
      s1 = {8'hBE};
      send_bytes(s1, 1'b0, "basic_sum");
      @(negedge clk);
      bus.rx_vld = 1'b0;
      wait_end("basic");
`endif
      check("basic_done_n2", done,     1'b1);
      check("basic_hold_n2", cpu_hold, 1'b0);
      check_log("basic", q);

      // Restart after DONE
      wr_log.delete();
      start_load(9'd1);
      check("restart_hold", cpu_hold, 1'b1);
      check("restart_done", done,     1'b0);
      check("restart_busy", busy,     1'b1);
      q = {8'h00, 8'h07};
      send_and_finish(q, 1'b0, "restart");
      check_log("restart", q);
      check("restart_done_again", done,     1'b1);
      check("restart_hold_rel",   cpu_hold, 1'b0);

      // Start while in HI is ignored: Len stays 2
      wr_log.delete();
      start_load(9'd2);
      start = 1'b1;
      len   = 9'd1;
      @(negedge clk);
      start = 1'b0;
      check("histart_busy", busy, 1'b1);
      q = {8'h5A, 8'hA5, 8'h3C, 8'hC3};
      send_and_finish(q, 1'b0, "histart");
      check_log("histart", q);

      // Table of loads, including full and clamped images
      for (int v = 0; v < vecs.size(); v++) begin
         run_load($sformatf("tbl%0d", v), vecs[v].len, vecs[v].nwords, vecs[v].stall);
         check($sformatf("tbl%0d_done", v), done,     vecs[v].exp_done);
         check($sformatf("tbl%0d_hold", v), cpu_hold, vecs[v].exp_hold);
      end

      // Randomized loads with random valid gaps
      for (int r = 0; r < 8; r++) begin
         rl = 9'($urandom_range(1, 12));
         run_load($sformatf("rnd%0d", r), rl, int'(rl), 1'($urandom));
         check($sformatf("rnd%0d_done", r), done, 1'b1);
      end

`ifdef CHECKSUM_EN
      // Checksum good then bad
      wr_log.delete();
      start_load(9'd1);
      q = {8'h01, 8'h02, 8'h03};
      send_bytes(q, 1'b0, "ck_good");
      @(negedge clk);
      bus.rx_vld = 1'b0;
      wait_end("ck_good");
      check("ck_good_done", done,     1'b1);
      check("ck_good_err",  err,      1'b0);
      check("ck_good_hold", cpu_hold, 1'b0);
      check("ck_good_w0",   wr_log.size() > 0 ? wr_log[0] : 24'hFFFFFF, 24'h000102);

      start_load(9'd1);
      q = {8'h01, 8'h02, 8'h04};
      send_bytes(q, 1'b0, "ck_bad");
      @(negedge clk);
      bus.rx_vld = 1'b0;
      wait_end("ck_bad");
      check("ck_bad_err",  err,      1'b1);
      check("ck_bad_hold", cpu_hold, 1'b1);
      check("ck_bad_done", done,     1'b0);
      check("ck_bad_busy", busy,     1'b0);

      run_load("ck_fail_exit", 9'd1, 1, 1'b0);
      check("ck_fail_exit_done", done, 1'b1);
`endif

      check("mem_en_eq_wr", en_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
